// File: rtl/host_mem_dma.sv
// host_mem_dma
//   Host-side burst engine for the host port of the data memory. One command
//   (write or read, base word address, length) becomes a run of single-word
//   memory accesses, at most one per cycle.
//     write: words arriving on the write stream are written to consecutive addresses
//     read : consecutive addresses are read and sent out on the read stream
//
// Handshake rule for every stream in this block: a transfer happens on a rising
// clock edge where valid and ready are both high. A source holds valid and its
// payload stable until that edge, and ready may depend combinationally on state.
//
// Ports
//   i_sys_clk, i_sys_rst          clock; synchronous active-low reset
//   i_cmd_*, o_cmd_ready          command channel (len 0 = no-op, >1024 clipped)
//   i_wdata*, o_wdata_ready       write stream into the memory
//   o_rdata*, i_rdata_ready       read stream out of the memory (registered)
//   o_host_*, i_host_dout         memory host port (combinational read, latency 0)
//   o_busy, o_done                not idle / one-cycle end-of-command pulse
//   o_dbg_state                   current FSM state (0 idle, 1 wr, 2 rd, 3 done)
module host_mem_dma #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 11
) (
  input  logic                i_sys_clk,
  input  logic                i_sys_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_wr,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [LEN_W-1:0]    i_cmd_len,
  input  logic                i_wdata_valid,
  output logic                o_wdata_ready,
  input  logic [WORD_LEN-1:0] i_wdata,
  output logic                o_rdata_valid,
  input  logic                i_rdata_ready,
  output logic [WORD_LEN-1:0] o_rdata,
  output logic                o_rdata_last,
  output logic                o_host_mem_wr_en,
  output logic                o_host_mem_rd_en,
  output logic [ADDR_W-1:0]   o_host_addr,
  output logic [WORD_LEN-1:0] o_host_din,
  input  logic [WORD_LEN-1:0] i_host_dout,
  output logic                o_busy,
  output logic                o_done,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Largest burst is one pass over the whole memory.
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr;
  logic [LEN_W-1:0]    rem;
  logic [WORD_LEN-1:0] rdata_q;
  logic                rdata_valid_q;
  logic                rdata_last_q;
  logic                done_q;

  logic [LEN_W-1:0]    len_clip;
  logic                cmd_fire;
  logic                wr_beat;
  logic                issue;
  logic                consume;

  assign len_clip = (i_cmd_len > MAX_LEN) ? MAX_LEN : i_cmd_len;
  assign cmd_fire = (state == S_IDLE) && i_cmd_valid;
  assign wr_beat  = (state == S_WR) && i_wdata_valid;
  // A new read may be issued when the output register is empty or is being
  // emptied this cycle, which gives one word per cycle under full ready.
  assign issue    = (state == S_RD) && (rem != '0) && (!rdata_valid_q || i_rdata_ready);
  assign consume  = rdata_valid_q && i_rdata_ready;

  always_comb begin
    state_nx         = state;
    o_cmd_ready      = 1'b0;
    o_wdata_ready    = 1'b0;
    o_host_mem_wr_en = 1'b0;
    o_host_mem_rd_en = 1'b0;
    o_host_addr      = '0;
    o_host_din       = '0;
    case (state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          if (len_clip == '0)  state_nx = S_DONE;
          else if (i_cmd_wr)   state_nx = S_WR;
          else                 state_nx = S_RD;
        end
      end
      S_WR: begin
        o_wdata_ready    = 1'b1;
        o_host_mem_wr_en = i_wdata_valid;
        o_host_addr      = addr;
        o_host_din       = i_wdata;
        if (i_wdata_valid && (rem == LEN_W'(1))) state_nx = S_DONE;
      end
      S_RD: begin
        o_host_mem_rd_en = issue;
        if (issue) o_host_addr = addr;
        // The burst ends once the word flagged last leaves the output register.
        if (consume && rdata_last_q) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      rem           <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state  <= state_nx;
      // done_q is high exactly while the FSM sits in DONE.
      done_q <= (state_nx == S_DONE);
      if (cmd_fire) begin
        addr <= i_cmd_addr;
        rem  <= len_clip;
      end
      if (wr_beat) begin
        addr <= addr + ADDR_W'(1);
        rem  <= rem - LEN_W'(1);
      end
      if (issue) begin
        rdata_q       <= i_host_dout;
        rdata_valid_q <= 1'b1;
        rdata_last_q  <= (rem == LEN_W'(1));
        addr          <= addr + ADDR_W'(1);
        rem           <= rem - LEN_W'(1);
      end else if (consume) begin
        rdata_valid_q <= 1'b0;
        rdata_last_q  <= 1'b0;
      end
    end
  end

  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_rdata_last  = rdata_last_q;
  assign o_done        = done_q;
  assign o_busy        = (state != S_IDLE);
  assign o_dbg_state   = state;

endmodule

// File: tb/tb_host_mem_dma.sv
// Testbench for host_mem_dma. Holds a 1024-word memory that the DUT drives
// through its host port, plus a reference copy of the memory contents that is
// updated from each command at the moment it is issued. Expected writes and
// read-stream words are queued at command issue; a negedge monitor pops them
// whenever the DUT writes memory or completes a read-stream transfer.
module tb_host_mem_dma;
  localparam int WL    = 32;
  localparam int AW    = 10;
  localparam int LW    = 11;
  localparam int DEPTH = 1024;

  logic          clk;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [WL-1:0] wdata;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [WL-1:0] rdata;
  logic          wr_en, rd_en;
  logic [AW-1:0] host_addr;
  logic [WL-1:0] host_din, host_dout;
  logic          busy, done;
  logic [1:0]    dbg_state;

  logic [WL-1:0] mem     [DEPTH];
  logic [WL-1:0] ref_mem [DEPTH];

  logic [AW+WL-1:0] exp_wr_q[$];
  logic [WL:0]      exp_rd_q[$];
  int               pending_done = 0;
  int               checks = 0;
  int               failures = 0;

  host_mem_dma dut (
    .i_sys_clk(clk), .i_sys_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
    .o_rdata_valid(rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(rdata),
    .o_rdata_last(rdata_last),
    .o_host_mem_wr_en(wr_en), .o_host_mem_rd_en(rd_en), .o_host_addr(host_addr),
    .o_host_din(host_din), .i_host_dout(host_dout),
    .o_busy(busy), .o_done(done), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign host_dout = mem[host_addr];
  always @(posedge clk) if (wr_en) mem[host_addr] <= host_din;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : monitor
    logic [AW+WL-1:0] ew;
    logic [WL:0]      er;
    if (rst) begin
      check("wr_rd_exclusive", {63'd0, wr_en & rd_en}, 64'd0);
      if (!busy) check("idle_no_access", {62'd0, wr_en, rd_en}, 64'd0);
      if (wr_en) begin
        if (exp_wr_q.size() == 0) check("spurious_wr", 64'd1, 64'd0);
        else begin
          ew = exp_wr_q.pop_front();
          check("wr_addr", 64'(host_addr), 64'(ew[AW+WL-1:WL]));
          check("wr_data", 64'(host_din), 64'(ew[WL-1:0]));
        end
      end
      if (rdata_valid && rdata_ready) begin
        if (exp_rd_q.size() == 0) check("spurious_rd_word", 64'd1, 64'd0);
        else begin
          er = exp_rd_q.pop_front();
          check("rd_word", 64'({rdata_last, rdata}), 64'(er));
        end
      end
      if (rdata_valid && !rdata_ready) check("no_rd_en_while_stalled", {63'd0, rd_en}, 64'd0);
      if (done) begin
        if (pending_done == 0) check("spurious_done", 64'd1, 64'd0);
        else pending_done--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers run at posedge+1 and decide handshakes at the negedge.
  task automatic send_cmd(input bit wr, input int a, input int len, output bit ok);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(len);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  // pat >= 0 gives data pat, pat+1, ...; otherwise random data.
  task automatic run_write(input int a, input int len, input int pat, input int gap_pct);
    bit ok;
    int n, i, budget;
    logic [WL-1:0] wq[$];
    logic [WL-1:0] d;
    n = (len > DEPTH) ? DEPTH : len;
    send_cmd(1'b1, a, len, ok);
    if (!ok) return;
    for (int k = 0; k < n; k++) begin
      d = (pat >= 0) ? WL'(pat + k) : WL'($urandom);
      wq.push_back(d);
      exp_wr_q.push_back({AW'((a + k) % DEPTH), d});
      ref_mem[(a + k) % DEPTH] = d;
    end
    pending_done++;
    i = 0;
    budget = 8 * n + 20;
    while (i < n && budget > 0) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        wdata_valid = 1'b0;
        wdata = WL'($urandom);
      end else begin
        wdata_valid = 1'b1;
        wdata = wq[i];
      end
      @(negedge clk);
      if (wdata_valid && wdata_ready) i++;
      @(posedge clk); #1;
      budget--;
    end
    if (i < n) check("wr_beat_timeout", 64'(i), 64'(n));
    // Keep offering junk through DONE: none of it may reach memory.
    wdata_valid = 1'b1;
    wdata = WL'($urandom);
    @(negedge clk);
    check("wr_done_pulse", {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_back_idle", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    wdata_valid = 1'b0;
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low on cycles 2-3.
  task automatic run_read(input int a, input int len, input int mode);
    bit ok, seen;
    int n, c, budget;
    n = (len > DEPTH) ? DEPTH : len;
    send_cmd(1'b0, a, len, ok);
    if (!ok) return;
    for (int k = 0; k < n; k++)
      exp_rd_q.push_back({(k == n - 1), ref_mem[(a + k) % DEPTH]});
    pending_done++;
    c = 0;
    seen = 1'b0;
    budget = 4 * n + 20;
    while (!seen && budget > 0) begin
      case (mode)
        1:       rdata_ready = 1'($urandom_range(1));
        2:       rdata_ready = !(c == 2 || c == 3);
        default: rdata_ready = 1'b1;
      endcase
      @(negedge clk);
      if (c == 0 && n > 0) begin
        check("rd_first_issue", {63'd0, rd_en}, 64'd1);
        check("rd_not_valid_at_entry", {63'd0, rdata_valid}, 64'd0);
      end
      if (c == 0 && n == 0) check("zero_len_no_rd", {63'd0, rd_en}, 64'd0);
      if (c == 1 && n > 0) check("rd_first_valid", {63'd0, rdata_valid}, 64'd1);
      if (done) seen = 1'b1;
      @(posedge clk); #1;
      c++;
      budget--;
    end
    if (!seen) check("rd_done_timeout", 64'd0, 64'd1);
    check("rd_all_words_seen", 64'(exp_rd_q.size()), 64'd0);
    check("rd_valid_clear_after", {63'd0, rdata_valid}, 64'd0);
    rdata_ready = 1'b0;
  endtask

  task automatic reset_mid_read();
    bit ok;
    send_cmd(1'b0, 'h010, 8, ok);
    if (!ok) return;
    for (int k = 0; k < 8; k++)
      exp_rd_q.push_back({(k == 7), ref_mem[('h010 + k) % DEPTH]});
    pending_done++;
    rdata_ready = 1'b1;
    // Entry cycle issues word 0; the next two edges consume words 0 and 1.
    repeat (3) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_words_left", 64'(exp_rd_q.size()), 64'd6);
    exp_rd_q.delete();
    pending_done = 0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_rdata_valid", {63'd0, rdata_valid}, 64'd0);
    check("rst_rdata_last", {63'd0, rdata_last}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    // Stay idle a few cycles; the monitor flags any late done pulse.
    repeat (5) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    rdata_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WL-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = WL'($urandom);
      mem[i] = w;
      ref_mem[i] = w;
    end
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("reset_outputs", {55'd0, busy, done, rdata_valid, rdata_last, wr_en, rd_en, wdata_ready, 2'd0},
          64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_write('h010, 4, 'hA0, 0);          // basic write
    run_read('h010, 4, 0);                 // read back A0..A3
    run_read('h010, 4, 2);                 // backpressure on cycles 2-3
    run_write('h3FE, 3, -1, 0);            // address wrap
    run_read('h3FE, 3, 0);
    run_write('h123, 1500, -1, 20);        // clipped to 1024 words
    run_read('h200, 2047, 0);              // clipped read over whole memory
    run_write('h050, 0, -1, 0);            // no-op write
    run_read('h050, 0, 0);                 // no-op read
    run_write('h060, 10, -1, 50);          // write stream with gaps
    run_read('h060, 10, 1);
    reset_mid_read();
    run_read('h3FE, 4, 0);                 // command accepted after reset

    for (int r = 0; r < 25; r++) begin
      int a, len;
      a   = int'($urandom_range(DEPTH - 1));
      len = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(40, 1));
      if ($urandom_range(1) == 1) run_write(a, len, -1, 30);
      else                        run_read(a, len, 1);
    end

    check("final_wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    check("final_rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
    check("final_done_balance", 64'(pending_done), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
